data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 105 ++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave: combinational grant, fixed-latency in-order responses, byte-enabled writes.
// Optional random grant stalls from a 16-bit LFSR when DATA_MEM_RESPONDER_STALL_EN is defined.
module data_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned RspLatency     = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);
    localparam int unsigned IdxW   = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [32:0] SpanB  = 33'(MemWords) << 2;
    localparam logic [3:0]  MaxOut = 4'(MaxOutstanding);
    localparam int          Last   = int'(RspLatency) - 1;

    logic [31:0]           mem_q [MemWords];
    logic [31:0]           offset;
    logic [IdxW-1:0]       idx;
    logic                  in_range;
    logic                  stall;
    logic                  gnt;
    logic                  rsp_vld;
    logic [3:0]            cnt_q, cnt_d, cnt_eff;
    logic [RspLatency-1:0] vld_q, err_q;
    logic [31:0]           dat_q [RspLatency];
    logic                  vld_d, err_d;
    logic [31:0]           dat_d;

    // BaseAddr is word aligned, so the low address bits never change the range decision.
    assign offset   = data_addr_i - BaseAddr;
    assign in_range = (data_addr_i >= BaseAddr) && ({1'b0, offset} < SpanB);
    assign idx      = offset[IdxW+1:2];

`ifdef DATA_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign stall  = lfsr_q[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    // A response leaving this cycle frees its slot for a new grant in the same cycle.
    assign rsp_vld = vld_q[Last];
    assign cnt_eff = cnt_q - {3'b000, rsp_vld};
    assign gnt     = rst_ni & data_req_i & (cnt_eff < MaxOut) & ~stall;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !rsp_vld)      cnt_d = cnt_q + 4'd1;
        else if (!gnt && rsp_vld) cnt_d = cnt_q - 4'd1;
        vld_d = gnt;
        err_d = gnt & ~in_range;
        dat_d = '0;
        if (gnt && in_range && !data_we_i) dat_d = mem_q[idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i <= Last; i++) dat_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            vld_q[0] <= vld_d;
            err_q[0] <= err_d;
            dat_q[0] <= dat_d;
            for (int i = 1; i <= Last; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rsp_vld;
    assign data_rdata_o  = dat_q[Last];
    assign data_err_o    = err_q[Last];
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default instance plus a MaxOutstanding=1 instance.
module tb_data_mem_responder;
    logic        clk;
    logic        rst_n;
    logic        d0_req, d0_we, d0_gnt, d0_rvalid, d0_err;
    logic [3:0]  d0_be;
    logic [31:0] d0_addr, d0_wdata, d0_rdata;
    logic        d1_req, d1_we, d1_gnt, d1_rvalid, d1_err;
    logic [3:0]  d1_be;
    logic [31:0] d1_addr, d1_wdata, d1_rdata;
    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    logic [31:0] s_addr [4];
    logic [31:0] s_exp  [4];

`ifdef DATA_MEM_RESPONDER_STALL_EN
    localparam int Gap0 = 0;
    localparam int Gap1 = 0;
`else
    localparam int Gap0 = 1;
    localparam int Gap1 = 2;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(d0_req), .data_we_i(d0_we), .data_be_i(d0_be),
        .data_addr_i(d0_addr), .data_wdata_i(d0_wdata),
        .data_gnt_o(d0_gnt), .data_rvalid_o(d0_rvalid),
        .data_rdata_o(d0_rdata), .data_err_o(d0_err)
    );

    data_mem_responder #(.MaxOutstanding(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(d1_req), .data_we_i(d1_we), .data_be_i(d1_be),
        .data_addr_i(d1_addr), .data_wdata_i(d1_wdata),
        .data_gnt_o(d1_gnt), .data_rvalid_o(d1_rvalid),
        .data_rdata_o(d1_rdata), .data_err_o(d1_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int g;
        bit got;
        g = 0; got = 1'b0; rdata = '0; err = 1'b0; lat = -1;
        @(posedge clk); #1;
        d0_req = 1'b1; d0_we = we; d0_be = be; d0_addr = addr; d0_wdata = wdata;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (d0_gnt) begin got = 1'b1; g = cyc; end
            @(posedge clk); #1;
        end
        d0_req = 1'b0;
        check_eq("gnt_seen", {31'b0, got}, 32'd1);
        if (!got) return;
        for (int i = 0; i < 16 && lat < 0; i++) begin
            @(negedge clk);
            if (d0_rvalid) begin rdata = d0_rdata; err = d0_err; lat = cyc - g; end
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_dat, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(we, be, addr, wdata, rd, er, lat);
        check_eq({tag, "_rdata"}, rd, exp_dat);
        check_eq({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        check_eq({tag, "_lat"}, lat, 32'd2);
    endtask

    // Holds req high over four transactions from s_addr/s_exp on the selected instance.
    task automatic run_stream(input bit sel, input bit we, input string tag, input int spacing);
        int gi, ri, idx;
        int gc [4];
        logic g, v, e;
        logic [31:0] rd;
        gi = 0; ri = 0;
        for (int c = 0; c < 400 && ri < 4; c++) begin
            @(posedge clk); #1;
            idx = (gi < 4) ? gi : 0;
            if (sel) begin
                d1_req = (gi < 4); d1_we = we; d1_be = 4'hF; d1_addr = s_addr[idx]; d1_wdata = s_exp[idx];
            end else begin
                d0_req = (gi < 4); d0_we = we; d0_be = 4'hF; d0_addr = s_addr[idx]; d0_wdata = s_exp[idx];
            end
            @(negedge clk);
            g  = sel ? d1_gnt    : d0_gnt;
            v  = sel ? d1_rvalid : d0_rvalid;
            e  = sel ? d1_err    : d0_err;
            rd = sel ? d1_rdata  : d0_rdata;
            if (v && ri < 4) begin
                check_eq({tag, "_rdata"}, rd, we ? 32'h0 : s_exp[ri]);
                check_eq({tag, "_err"}, {31'b0, e}, 32'd0);
                check_eq({tag, "_lat"}, cyc - gc[ri], 32'd2);
                ri++;
            end else if (!v) begin
                check_eq({tag, "_idle_rdata"}, rd, 32'h0);
                check_eq({tag, "_idle_err"}, {31'b0, e}, 32'd0);
            end
            if (g && gi < 4) begin
                if (spacing > 0 && gi > 0) check_eq({tag, "_gnt_gap"}, cyc - gc[gi-1], spacing);
                gc[gi] = cyc;
                gi++;
            end
        end
        d0_req = 1'b0;
        d1_req = 1'b0;
        check_eq({tag, "_rsp_count"}, ri, 32'd4);
    endtask

`ifdef DATA_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    task automatic random_stall_run();
        logic [31:0] mm [8];
        logic [31:0] q_dat [$];
        logic        q_err [$];
        int          q_cyc [$];
        int          issued, answered, k;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd, ed;
        for (int w = 0; w < 8; w++) begin
            mm[w] = 32'h1000_0000 + 32'(w);
            txn("pre_wr", 1'b1, 4'hF, 32'h0010_0000 + 32'(4 * w), mm[w], 32'h0, 1'b0);
        end
        issued = 0; answered = 0;
        k = $urandom_range(0, 8); we = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15)); wd = $urandom;
        for (int c = 0; c < 5000 && answered < 100; c++) begin
            @(posedge clk); #1;
            d0_req = (issued < 100); d0_we = we; d0_be = be; d0_wdata = wd;
            d0_addr = (k == 8) ? 32'h0010_1000 : 32'h0010_0000 + 32'(4 * k);
            @(negedge clk);
            if (lfsr_m[0]) check_eq("stall_gnt", {31'b0, d0_gnt}, 32'd0);
            if (d0_rvalid) begin
                check_eq("rnd_rsp_expected", q_cyc.size(), q_cyc.size() == 0 ? 32'd1 : q_cyc.size());
                if (q_cyc.size() > 0) begin
                    check_eq("rnd_rdata", d0_rdata, q_dat.pop_front());
                    check_eq("rnd_err", {31'b0, d0_err}, {31'b0, q_err.pop_front()});
                    check_eq("rnd_lat", cyc - q_cyc.pop_front(), 32'd2);
                end
                answered++;
            end
            if (d0_gnt && issued < 100) begin
                ed = '0;
                if (k < 8 && !we) ed = mm[k];
                if (k < 8 && we) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mm[k][8*b +: 8] = wd[8*b +: 8];
                end
                q_dat.push_back(ed);
                q_err.push_back(k == 8);
                q_cyc.push_back(cyc);
                issued++;
                k = $urandom_range(0, 8); we = 1'($urandom_range(0, 1)); be = 4'($urandom_range(0, 15)); wd = $urandom;
            end
        end
        d0_req = 1'b0;
        check_eq("rnd_answered", answered, 32'd100);
        check_eq("rnd_queue_empty", q_cyc.size(), 32'd0);
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, n_checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int n_gnt, n_rv;
        rst_n = 1'b0;
        d0_req = 1'b1; d0_we = 1'b0; d0_be = 4'h0; d0_addr = 32'h0010_0000; d0_wdata = '0;
        d1_req = 1'b1; d1_we = 1'b0; d1_be = 4'h0; d1_addr = 32'h0010_0000; d1_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt", {31'b0, d0_gnt}, 32'd0);
        check_eq("rst_rvalid", {31'b0, d0_rvalid}, 32'd0);
        check_eq("rst_rdata", d0_rdata, 32'h0);
        check_eq("rst_err", {31'b0, d0_err}, 32'd0);
        check_eq("rst_gnt1", {31'b0, d1_gnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; d0_req = 1'b0; d1_req = 1'b0;

        txn("wr_beef",       1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 32'h0,          1'b0);
        txn("rd_beef",       1'b0, 4'hF, 32'h0010_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
        txn("rd_unaligned",  1'b0, 4'h0, 32'h0010_0013, 32'h0,         32'hDEAD_BEEF, 1'b0);
        txn("wr_be0",        1'b1, 4'h0, 32'h0010_0010, 32'h0,         32'h0,          1'b0);
        txn("rd_be0_kept",   1'b0, 4'hF, 32'h0010_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
        txn("wr_full",       1'b1, 4'hF, 32'h0010_0020, 32'h1122_3344, 32'h0,          1'b0);
        txn("wr_be5",        1'b1, 4'h5, 32'h0010_0020, 32'hAABB_CCDD, 32'h0,          1'b0);
        txn("rd_be5",        1'b0, 4'hF, 32'h0010_0020, 32'h0,         32'h11BB_33DD, 1'b0);
        txn("wr_w0",         1'b1, 4'hF, 32'h0010_0000, 32'hCAFE_F00D, 32'h0,          1'b0);
        txn("wr_last",       1'b1, 4'hF, 32'h0010_0FFC, 32'h5A5A_5A5A, 32'h0,          1'b0);
        txn("rd_past_end",   1'b0, 4'hF, 32'h0010_1000, 32'h0,         32'h0,          1'b1);
        txn("wr_past_end",   1'b1, 4'hF, 32'h0010_1000, 32'h1234_5678, 32'h0,          1'b1);
        txn("wr_below_base", 1'b1, 4'hF, 32'h000F_FFFC, 32'hFFFF_FFFF, 32'h0,          1'b1);
        txn("rd_w0_kept",    1'b0, 4'hF, 32'h0010_0000, 32'h0,         32'hCAFE_F00D, 1'b0);
        txn("rd_last_kept",  1'b0, 4'hF, 32'h0010_0FFC, 32'h0,         32'h5A5A_5A5A, 1'b0);

        s_addr = '{32'h0010_0010, 32'h0010_0020, 32'h0010_0000, 32'h0010_0FFC};
        s_exp  = '{32'hDEAD_BEEF, 32'h11BB_33DD, 32'hCAFE_F00D, 32'h5A5A_5A5A};
        run_stream(1'b0, 1'b0, "s0_rd", Gap0);

        s_addr = '{32'h0010_0040, 32'h0010_0044, 32'h0010_0048, 32'h0010_004C};
        s_exp  = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
        run_stream(1'b1, 1'b1, "s1_wr", Gap1);
        run_stream(1'b1, 1'b0, "s1_rd", Gap1);

        // Two reads in flight, then reset before either response is seen.
        n_gnt = 0;
        @(posedge clk); #1;
        d0_req = 1'b1; d0_we = 1'b0; d0_be = 4'hF; d0_addr = 32'h0010_0010;
        for (int i = 0; i < 64 && n_gnt < 2; i++) begin
            @(negedge clk);
            if (d0_gnt) n_gnt++;
            @(posedge clk); #1;
            if (n_gnt == 1) d0_addr = 32'h0010_0020;
        end
        check_eq("rst_mid_grants", n_gnt, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_rvalid", {31'b0, d0_rvalid}, 32'd0);
        check_eq("rst_mid_gnt", {31'b0, d0_gnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; d0_req = 1'b0;
        n_rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d0_rvalid) n_rv++;
        end
        check_eq("rst_mid_no_rsp", n_rv, 32'd0);
        txn("rd_after_rst", 1'b0, 4'hF, 32'h0010_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef DATA_MEM_RESPONDER_STALL_EN
        random_stall_run();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
